imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot sequencer that sits between an external byte-stream source and the CPU's instruction memory write port.
- Receives a length header and then instruction words over a valid/ready byte interface, and writes them into instruction memory from word index 0.
- Holds the CPU reset asserted while loading, then for a fixed hold period, then releases it.
- Replaces the bench-only preload of instruction memory with a synthesizable load path.

Parameters:
- ADDR_W, 8, instruction memory word-index width; depth = 2**ADDR_W words.
- RST_HOLD, 3, number of cycles cpu_rst_ stays low after the last write before release; minimum 1.
- BIG_ENDIAN, 1, byte order: 1 = first byte received is bits [31:24]; 0 = first byte received is bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream data valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse; restarts loading from RUN or ERROR.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  instruction memory word index.
- imem_wdata  out  32  instruction memory write data.
- cpu_rst_  out  1  active-low reset to the CPU core.
- busy  out  1  high in HDR, LOAD, CSUM and HOLD.
- done  out  1  high in RUN.
- error  out  1  high in ERROR.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset is asynchronous and active-low. While rst_=0:
  - state=HDR;
  - in_ready, imem_we, done, error = 0;
  - imem_addr, imem_wdata, words_loaded = 0;
  - cpu_rst_=0;
  - busy=1.
- Byte transfer: a byte transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is registered; it is 1 only in HDR, LOAD and CSUM.
  - in_data is ignored when no transfer occurs.
- Word assembly: a 2-bit byte counter packs 4 transferred bytes into one 32-bit word, ordered per BIG_ENDIAN. The counter clears on every state change.
- HDR: the first word is the length N (unsigned, 32 bits).
  - N=0 goes to HOLD (or CSUM when CHECKSUM_EN is defined).
  - N > 2**ADDR_W goes to ERROR.
  - Otherwise goes to LOAD.
- LOAD: each assembled word produces a write.
  - Latency: the 4th byte transfers at edge k; imem_we=1 for exactly the cycle following edge k.
  - imem_addr equals the current words_loaded and imem_wdata equals the word.
  - words_loaded increments at that same edge k.
  - When words_loaded reaches N, go to HOLD (or CSUM). In_ready drops in the same edge.
- HOLD: a counter runs RST_HOLD cycles with cpu_rst_=0, then the block goes to RUN.
- RUN: cpu_rst_=1 and done=1 (both registered, asserted at the same edge). in_ready=0.
- ERROR: error=1, cpu_rst_=0, in_ready=0, imem_we=0.
- Exit from RUN and ERROR is only via reload or rst_.
- reload:
  - Sampled only in RUN and ERROR; ignored in every other state.
  - On the edge it is sampled: go to HDR, cpu_rst_ goes 0, words_loaded clears, done/error clear.
- Last-word address: the final write of a full load (N = 2**ADDR_W) uses imem_addr = 2**ADDR_W-1. There is no wrap; words_loaded reaches 2**ADDR_W.
- Reset mid-load: rst_ low in any state aborts at once. Memory contents already written are left as-is, and loading restarts at HDR.
- Simultaneous events: reload asserted in the same cycle as a transfer attempt has no effect on the transfer, because in_ready=0 in RUN and ERROR.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the N data words, state CSUM receives one more word C.
  - C must equal the 32-bit wrap-around sum of N plus all data words.
  - Match goes to HOLD; mismatch goes to ERROR.
  - No imem write occurs for C.
- Not defined: CSUM does not exist; LOAD/HDR go directly to HOLD.

Decomposition:
- Package imem_boot_pkg:
  - state enum {HDR, LOAD, CSUM, HOLD, RUN, ERROR};
  - constant WORD_W=32;
  - constant BYTE_W=8.
- Sub-module byte_word_packer:
  - byte counter and shift register;
  - inputs: byte strobe, clear;
  - outputs: word_valid pulse and 32-bit word;
  - BIG_ENDIAN parameter.
- The FSM, address counter and hold counter stay in the top module.

Test Plan:
- Basic load: BIG_ENDIAN=1, stream 00 00 00 02 / 01 2A 40 20 / AC 0B 00 04, in_valid always 1.
  - Expect imem_we pulses with (addr 0, 012A4020) and (addr 1, AC0B0004).
  - Expect words_loaded=2, and cpu_rst_ rising exactly 3 cycles after the last imem_we cycle ends, together with done=1.
- Backpressure and gaps: same stream with in_valid toggled 1/0 every cycle.
  - Expect identical writes and data.
  - No byte is lost or duplicated.
- Boundaries:
  - Header N=0: no imem_we, HOLD 3 cycles, then RUN.
  - With ADDR_W=2, header N=5: ERROR, error=1, cpu_rst_=0, in_ready=0.
  - With ADDR_W=2, N=4: last write at addr 3, then RUN.
- Reset mid-load: assert rst_=0 after 1.5 data words.
  - Expect all outputs at their reset values immediately (asynchronously).
  - After release, a new header is accepted and loading restarts at addr 0.
- reload: reload pulse from RUN; then a new load with N=1.
  - Expect cpu_rst_=0 on the next cycle and a write to addr 0.
  - Expect a reload pulse during LOAD to be ignored.
- IMEM_BOOT_CHECKSUM_EN:
  - N=1, word 00000010, C=00000011: RUN.
  - C=00000012: ERROR, with imem contents written but cpu_rst_ held low.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CSUM,
        HOLD,
        RUN,
        ERROR
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(state_t s);
        return (s == HDR) || (s == LOAD) || (s == CSUM);
    endfunction

    // States in which a boot is still in progress.
    function automatic logic is_busy(state_t s);
        return accepts_bytes(s) || (s == HOLD);
    endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs a byte stream into 32-bit words. The word and its valid pulse are
// combinational on the strobe of the 4th byte, so the consumer can register
// the word on the same edge that transfers that byte.
module byte_word_packer
    import imem_boot_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              strobe,
    input  logic              clear,
    input  logic [BYTE_W-1:0] din,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;

    // Shift the incoming byte in from the side that keeps the first byte at its final lane.
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            shreg_nxt = {shreg[WORD_W-BYTE_W-1:0], din};
        end else begin
            shreg_nxt = {din, shreg[WORD_W-1:BYTE_W]};
        end
    end

    assign word       = shreg_nxt;
    assign word_valid = strobe && (cnt == 2'd3);

    // Byte position within the current word; a state change restarts it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (strobe) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Byte shift register; stale bytes are shifted out before they can matter.
    always_ff @(posedge clk) begin
        if (strobe) begin
            shreg <= shreg_nxt;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length header and instruction words over a
// valid/ready byte stream, writes them to instruction memory from index 0,
// then holds the CPU in reset for RST_HOLD more cycles before releasing it.
// Optional checksum word after the data: define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RST_HOLD   = 3,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [WORD_W:0] DEPTH_EXT = {{WORD_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [ADDR_W:0] WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t LOAD_EXIT = CSUM;
`else
    localparam state_t LOAD_EXIT = HOLD;
`endif

    state_t              state;
    state_t              state_nxt;
    logic                xfer;
    logic                pk_vld;
    logic [WORD_W-1:0]   pk_word;
    logic                pk_clear;
    logic                load_wr;
    logic                restart;
    logic [ADDR_W:0]     wl_inc;
    logic [ADDR_W:0]     len_q;
    logic [HOLD_W-1:0]   hold_cnt;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [WORD_W-1:0]   sum_q;
`endif

    assign xfer     = in_valid && in_ready;
    assign load_wr  = (state == LOAD) && pk_vld;
    assign restart  = ((state == RUN) || (state == ERROR)) && reload;
    assign wl_inc   = words_loaded + WL_ONE;
    assign pk_clear = (state_nxt != state);

    byte_word_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk        (clk),
        .rst_       (rst_),
        .strobe     (xfer),
        .clear      (pk_clear),
        .din        (in_data),
        .word_valid (pk_vld),
        .word       (pk_word)
    );

    // Next-state decision; every transition out of a byte-taking state lands on a word boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (pk_vld) begin
                    if (pk_word == '0) begin
                        state_nxt = LOAD_EXIT;
                    end else if ({1'b0, pk_word} > DEPTH_EXT) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pk_vld && (wl_inc == len_q)) begin
                    state_nxt = LOAD_EXIT;
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CSUM: begin
                if (pk_vld) begin
                    state_nxt = (pk_word == sum_q) ? HOLD : ERROR;
                end
            end
`endif
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN, ERROR: begin
                if (reload) begin
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // Main FSM with all status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= HDR;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            cpu_rst_     <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= accepts_bytes(state_nxt);
            busy     <= is_busy(state_nxt);
            done     <= (state_nxt == RUN);
            cpu_rst_ <= (state_nxt == RUN);
            error    <= (state_nxt == ERROR);
            imem_we  <= load_wr;
            hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_ONE : '0;
            if (load_wr) begin
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= pk_word;
                words_loaded <= wl_inc;
            end else if (restart) begin
                words_loaded <= '0;
            end
        end
    end

    // Capture the header length; only consulted while in LOAD.
    always_ff @(posedge clk) begin
        if ((state == HDR) && pk_vld) begin
            len_q <= pk_word[ADDR_W:0];
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Running wrap-around sum of the header and every data word.
    always_ff @(posedge clk) begin
        if ((state == HDR) && pk_vld) begin
            sum_q <= pk_word;
        end else if (load_wr) begin
            sum_q <= sum_q + pk_word;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (default 8-bit/big-endian and
// 2-bit/little-endian) share the stimulus; sel picks the active one.
module tb_imem_boot_loader;

    localparam int AW_A   = 8;
    localparam int AW_B   = 2;
    localparam int HOLD_A = 3;
    localparam int HOLD_B = 2;

    logic clk = 1'b0;
    logic rst_ = 1'b1;
    logic in_valid = 1'b0;
    logic reload = 1'b0;
    logic sel = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic a_ready, a_we, a_cpu, a_busy, a_done, a_err;
    logic [AW_A-1:0] a_addr;
    logic [31:0]     a_wdata;
    logic [AW_A:0]   a_wl;
    logic b_ready, b_we, b_cpu, b_busy, b_done, b_err;
    logic [AW_B-1:0] b_addr;
    logic [31:0]     b_wdata;
    logic [AW_B:0]   b_wl;

    logic o_ready, o_we, o_cpu, o_busy, o_done, o_err;
    logic [7:0]  o_addr;
    logic [31:0] o_wdata;
    logic [8:0]  o_wl;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          wr_cyc[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];

    int tx_last_edge;
    int tx_word_edge[$];
    bit tx_ok;

    imem_boot_loader #(.ADDR_W(AW_A), .RST_HOLD(HOLD_A), .BIG_ENDIAN(1)) u_dut_a (
        .clk(clk), .rst_(rst_), .in_valid(in_valid && !sel), .in_data(in_data),
        .in_ready(a_ready), .reload(reload && !sel), .imem_we(a_we), .imem_addr(a_addr),
        .imem_wdata(a_wdata), .cpu_rst_(a_cpu), .busy(a_busy), .done(a_done),
        .error(a_err), .words_loaded(a_wl)
    );

    imem_boot_loader #(.ADDR_W(AW_B), .RST_HOLD(HOLD_B), .BIG_ENDIAN(0)) u_dut_b (
        .clk(clk), .rst_(rst_), .in_valid(in_valid && sel), .in_data(in_data),
        .in_ready(b_ready), .reload(reload && sel), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .cpu_rst_(b_cpu), .busy(b_busy), .done(b_done),
        .error(b_err), .words_loaded(b_wl)
    );

    always_comb begin
        o_ready = sel ? b_ready : a_ready;
        o_we    = sel ? b_we    : a_we;
        o_cpu   = sel ? b_cpu   : a_cpu;
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_err   = sel ? b_err   : a_err;
        o_addr  = sel ? {6'b0, b_addr} : a_addr;
        o_wdata = sel ? b_wdata : a_wdata;
        o_wl    = sel ? {6'b0, b_wl} : a_wl;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(o_addr));
            wr_data.push_back(o_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive words byte by byte in the active instance's byte order; records accept edges.
    task automatic send_words(input logic [31:0] w[$], input int gap, input int reload_byte,
                              input int max_bytes);
        bit be;
        bit tog;
        bit rdy;
        bit acc;
        int nb;
        int tries;
        int edge_now;
        logic [7:0] b;
        be = (sel == 1'b0);
        tog = 1'b1;
        nb = 0;
        tx_ok = 1'b1;
        tx_last_edge = -1;
        tx_word_edge = {};
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (max_bytes >= 0 && nb >= max_bytes) return;
                b = be ? w[i][31-8*k -: 8] : w[i][8*k +: 8];
                acc = 1'b0;
                tries = 0;
                while (!acc) begin
                    @(negedge clk);
                    case (gap)
                        0: in_valid = 1'b1;
                        1: begin in_valid = tog; tog = ~tog; end
                        default: in_valid = ($urandom_range(0, 2) != 0);
                    endcase
                    in_data = in_valid ? b : 8'($urandom);
                    reload = (nb == reload_byte) && (tries == 0);
                    rdy = o_ready;
                    edge_now = cyc + 1;
                    @(posedge clk);
                    if (in_valid && rdy) begin
                        acc = 1'b1;
                        tx_last_edge = edge_now;
                    end
                    tries++;
                    if (!acc && tries > 40) begin
                        tx_ok = 1'b0;
                        return;
                    end
                end
                nb++;
                if (k == 3) tx_word_edge.push_back(tx_last_edge);
            end
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        in_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    // One full boot from HDR: builds the stream from N and data, predicts writes and the outcome.
    task automatic test_load_scenario(input string name, input logic [31:0] n,
                                      input logic [31:0] data[$], input int gap,
                                      input bit bad_csum, input int reload_byte);
        int depth;
        int hold;
        int exp_wr;
        int exp_seen;
        int seen;
        int nwr;
        bit exp_err;
        logic [31:0] w[$];
        logic [31:0] csum;
        logic [4:0] st;
        logic [4:0] exp_st;
        depth = sel ? (1 << AW_B) : (1 << AW_A);
        hold  = sel ? HOLD_B : HOLD_A;
        w = {};
        w.push_back(n);
        exp_err = (n > depth);
        exp_wr = exp_err ? 0 : int'(n);
        if (!exp_err) begin
            csum = n;
            for (int i = 0; i < exp_wr; i++) begin
                w.push_back(data[i]);
                csum = csum + data[i];
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            w.push_back(bad_csum ? csum + 32'd1 : csum);
            exp_err = bad_csum;
`endif
        end
        wr_cyc = {};
        wr_addr = {};
        wr_data = {};
        send_words(w, gap, reload_byte, -1);
        n_cmp++;
        if (!tx_ok) begin
            n_bad++;
            $display("FAIL %s stream: byte not accepted within bound (accepted words=%0d, required=%0d)",
                     name, tx_word_edge.size(), w.size());
        end
        seen = -1;
        for (int t = 0; t < hold + 10 && seen < 0; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            reload = 1'b0;
            if (o_cpu === 1'b1 || o_err === 1'b1) seen = cyc;
        end
        exp_seen = exp_err ? tx_last_edge : tx_last_edge + hold + 1;
        n_cmp++;
        if (seen !== exp_seen) begin
            n_bad++;
            $display("FAIL %s outcome_cycle: got %0d, expected %0d", name, seen, exp_seen);
        end
        st = {o_cpu, o_done, o_err, o_busy, o_ready};
        exp_st = exp_err ? 5'b00100 : 5'b11000;
        n_cmp++;
        if (st !== exp_st) begin
            n_bad++;
            $display("FAIL %s status{cpu,done,err,busy,ready}: got %b, expected %b", name, st, exp_st);
        end
        n_cmp++;
        if (wr_cyc.size() != exp_wr) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d, expected %0d", name, wr_cyc.size(), exp_wr);
        end
        for (int i = 0; i < exp_wr; i++) begin
            n_cmp++;
            if (i >= wr_cyc.size() || i + 1 >= tx_word_edge.size()) begin
                n_bad++;
                $display("FAIL %s write[%0d]: missing, expected addr %0d data %08h", name, i, i, data[i]);
            end else if (wr_addr[i] != i || wr_data[i] !== data[i] || wr_cyc[i] != tx_word_edge[i+1]) begin
                n_bad++;
                $display("FAIL %s write[%0d]: got addr %0d data %08h cycle %0d, expected addr %0d data %08h cycle %0d",
                         name, i, wr_addr[i], wr_data[i], wr_cyc[i], i, data[i], tx_word_edge[i+1]);
            end
        end
        n_cmp++;
        if (o_wl !== 9'(exp_wr)) begin
            n_bad++;
            $display("FAIL %s words_loaded: got %0d, expected %0d", name, o_wl, exp_wr);
        end
        nwr = wr_cyc.size();
        repeat (5) @(negedge clk);
        st = {o_cpu, o_done, o_err, o_busy, o_ready};
        n_cmp++;
        if (st !== exp_st || wr_cyc.size() != nwr) begin
            n_bad++;
            $display("FAIL %s settled: status %b writes %0d, expected status %b writes %0d",
                     name, st, wr_cyc.size(), exp_st, nwr);
        end
    endtask

    task automatic test_reset();
        logic [54:0] v;
        logic [54:0] exp_v;
        exp_v = {6'b000001, 8'h00, 32'h0, 9'h0};
        #2 rst_ = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            v = {o_ready, o_we, o_done, o_err, o_cpu, o_busy, o_addr, o_wdata, o_wl};
            n_cmp++;
            if (v !== exp_v) begin
                n_bad++;
                $display("FAIL reset_values dut%0d: got %h, expected %h", s, v, exp_v);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_ready, o_busy, o_cpu, o_done} !== 4'b1100) begin
            n_bad++;
            $display("FAIL after_reset{ready,busy,cpu,done}: got %b, expected 1100",
                     {o_ready, o_busy, o_cpu, o_done});
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] d[$];
        sel = 1'b0;
        d = {};
        d.push_back(32'h012A4020);
        d.push_back(32'hAC0B0004);
        test_load_scenario("basic", 32'd2, d, 0, 1'b0, -1);
        pulse_reload();
        test_load_scenario("toggle_valid", 32'd2, d, 1, 1'b0, -1);
        pulse_reload();
    endtask

    task automatic test_random();
        logic [31:0] d[$];
        int n;
        sel = 1'b0;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 6);
            d = {};
            for (int i = 0; i < n; i++) d.push_back($urandom);
            test_load_scenario("random_gaps", 32'(n), d, 2, 1'b0, -1);
            pulse_reload();
        end
    endtask

    task automatic test_hdr_zero();
        logic [31:0] d[$];
        sel = 1'b0;
        d = {};
        test_load_scenario("hdr_zero", 32'd0, d, 0, 1'b0, 1);
        pulse_reload();
    endtask

    task automatic test_small_depth();
        logic [31:0] d[$];
        sel = 1'b1;
        d = {};
        test_load_scenario("hdr_too_big", 32'd5, d, 0, 1'b0, -1);
        pulse_reload();
        n_cmp++;
        if ({o_err, o_ready, o_busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL reload_from_error{err,ready,busy}: got %b, expected 011", {o_err, o_ready, o_busy});
        end
        for (int i = 0; i < 4; i++) d.push_back($urandom);
        test_load_scenario("full_depth", 32'd4, d, 2, 1'b0, -1);
        pulse_reload();
        test_load_scenario("hdr_huge", 32'hFFFF_FFFF, d, 0, 1'b0, -1);
        pulse_reload();
        sel = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [31:0] w[$];
        logic [31:0] d[$];
        logic [54:0] v;
        sel = 1'b0;
        w = {};
        w.push_back(32'd4);
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        wr_cyc = {};
        wr_addr = {};
        wr_data = {};
        send_words(w, 0, -1, 10);
        #2;
        rst_ = 1'b0;
        in_valid = 1'b0;
        #1;
        v = {o_ready, o_we, o_done, o_err, o_cpu, o_busy, o_addr, o_wdata, o_wl};
        n_cmp++;
        if (v !== {6'b000001, 8'h00, 32'h0, 9'h0}) begin
            n_bad++;
            $display("FAIL midload_reset_values: got %h, expected %h", v, {6'b000001, 8'h00, 32'h0, 9'h0});
        end
        n_cmp++;
        if (wr_cyc.size() != 1 || wr_data[0] !== w[1]) begin
            n_bad++;
            $display("FAIL midload_writes_before_reset: got %0d writes, expected 1 of %08h", wr_cyc.size(), w[1]);
        end
        @(negedge clk);
        rst_ = 1'b1;
        d = {};
        d.push_back($urandom);
        d.push_back($urandom);
        test_load_scenario("after_midload_reset", 32'd2, d, 2, 1'b0, -1);
    endtask

    task automatic test_reload();
        logic [31:0] d[$];
        sel = 1'b0;
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_cmp++;
        if ({o_cpu, o_done, o_err, o_ready, o_busy} !== 5'b00011 || o_wl !== 9'd0) begin
            n_bad++;
            $display("FAIL reload_from_run{cpu,done,err,ready,busy}: got %b wl %0d, expected 00011 wl 0",
                     {o_cpu, o_done, o_err, o_ready, o_busy}, o_wl);
        end
        d = {};
        d.push_back($urandom);
        test_load_scenario("reload_n1_ignored_in_load", 32'd1, d, 0, 1'b0, 6);
        pulse_reload();
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] d[$];
        sel = 1'b0;
        d = {};
        d.push_back(32'h0000_0010);
        test_load_scenario("csum_good", 32'd1, d, 0, 1'b0, -1);
        pulse_reload();
        test_load_scenario("csum_bad", 32'd1, d, 0, 1'b1, -1);
        pulse_reload();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_hdr_zero();
        test_random();
        test_small_depth();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        test_reload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
